// File: rtl/tree_node_arb.sv
// Round-robin tree-node arbiter: merges NUM_CHILD valid/ready children into one buffered upstream port.
// Latency: 1 cycle minimum from child transfer to up_valid; no same-cycle bypass.
// Backpressure: child_ready drops to all-zero while the FIFO is full, even if a pop happens that cycle.
module tree_node_arb #(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        up_valid,
    output logic [DATA_W-1:0]           up_data,
    output logic [ID_W-1:0]             up_id,
    input  logic                        up_ready,
    output logic [CNT_W-1:0]            fill_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   scan;
    logic [ID_W-1:0]   win_idx;
    logic [DATA_W-1:0] win_dat;
    logic              found;
    logic              full;
    logic              push;
    logic              pop;

    assign full = (fill_count == CNT_W'(FIFO_DEPTH));

    // Walk children starting at rr_ptr, wrapping at NUM_CHILD; first valid one wins.
    always_comb begin
        scan    = rr_ptr;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            if (!found && child_valid[scan]) begin
                found   = 1'b1;
                win_idx = scan;
            end
            scan = (scan == ID_W'(NUM_CHILD - 1)) ? '0 : scan + ID_W'(1);
        end
        push = found && !full && !rst;
    end

    always_comb begin
        child_ready = '0;
        if (push) begin
            child_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_dat = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_dat = child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign up_valid = (fill_count != '0);
    assign pop      = up_valid && up_ready;
    assign up_data  = mem[rd_ptr].dat;
    assign up_id    = mem[rd_ptr].id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (win_idx == ID_W'(NUM_CHILD - 1)) ? '0 : win_idx + ID_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fill_count <= fill_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{id: win_idx, dat: win_dat};
        end
    end
endmodule

// File: doc/tree_node_arb.md
TREE_NODE_ARB -- requirements
Module: tree_node_arb

Interface
REQ-001 SHALL have parameter NUM_CHILD, default 5: number of child channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 16: child payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two, legal range 2..64.
REQ-004 SHALL derive localparam ID_W = max(1, clog2(NUM_CHILD)) and CNT_W = clog2(FIFO_DEPTH)+1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-006 child_valid  input  NUM_CHILD  per-child request.
REQ-007 child_data  input  NUM_CHILD*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W].
REQ-008 child_ready  output  NUM_CHILD  one-hot grant (or all zero).
REQ-009 up_valid  output  1  buffered entry available.
REQ-010 up_data  output  DATA_W  payload of head entry.
REQ-011 up_id  output  ID_W  source child index of head entry.
REQ-012 up_ready  input  1  upstream accepts head entry.
REQ-013 fill_count  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-014 SHALL form a push candidate each cycle when the FIFO is not full (fill_count < FIFO_DEPTH) and any child_valid bit is set.
REQ-015 SHALL pick the candidate by round-robin: search starts at index rr_ptr and wraps modulo NUM_CHILD; the first valid child wins.
REQ-016 SHALL drive child_ready combinationally: one-hot at the winner, all zero when the FIFO is full or no child is valid.
REQ-017 SHALL treat a transfer as child_valid[i] && child_ready[i]; on a transfer, it writes {i, child_data[i]} into the FIFO tail.
REQ-018 SHALL update rr_ptr on a transfer to (winner+1) mod NUM_CHILD, and hold rr_ptr otherwise.
REQ-019 SHALL accept at most one child per cycle.
REQ-020 SHALL drive up_valid = (fill_count != 0), with up_data and up_id taken from the FIFO head register (registered, not combinational from child inputs).
REQ-021 SHALL pop the head on up_valid && up_ready.
REQ-022 SHALL have a minimum latency of 1 cycle: data accepted at edge t appears on up_valid/up_data after edge t.
REQ-023 SHALL provide no same-cycle bypass from child to up.
REQ-024 SHALL, on simultaneous push and pop with the FIFO not full, leave fill_count unchanged and write/read both correctly.
REQ-025 SHALL, when full, assert no child_ready even if a pop occurs in the same cycle (no push-on-pop-when-full).
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH; fill_count never exceeds FIFO_DEPTH and never underflows.
REQ-027 SHALL, while up_valid is high and up_ready is low, hold up_data and up_id stable.
REQ-028 SHALL impose no constraints on child_data when child_valid is low; children may deassert valid without a grant.

Reset
REQ-029 SHALL, on rst assertion, immediately clear rr_ptr to 0, read/write pointers to 0, fill_count to 0 and up_valid to 0, independent of clk.
REQ-030 SHALL discard FIFO contents on reset mid-operation; payload storage needs no reset.
REQ-031 SHALL hold child_ready all zero during reset and resume arbitration at the first rising clk edge after rst deasserts.

Verification (NUM_CHILD=5, DATA_W=16, FIFO_DEPTH=4)
REQ-032 SHALL verify the reset case: rst pulse mid-traffic with 3 entries buffered -> up_valid=0, fill_count=0 and child_ready=0 asynchronously; the next grant goes to the lowest valid index >= 0.
REQ-033 SHALL verify round-robin: all 5 children valid continuously with up_ready=1 -> grants in order 0,1,2,3,4,0,... and up_id sequence is the same, one cycle later.
REQ-034 SHALL verify the full case: up_ready=0 and children 1 and 3 valid -> 4 entries accepted (ids 1,3,1,3), fill_count=4, then child_ready=0; up_ready pulsed for 1 cycle -> fill_count=3, with no push that cycle and a push the next cycle.
REQ-035 SHALL verify simultaneous push/pop: steady state with fill_count=2, up_ready=1 and child 2 valid -> fill_count stays 2 and data emerges in order.
REQ-036 SHALL verify the sparse case: only child 4 valid with data 0xBEEF, then only child 0 with data 0x1234 -> up_id/up_data = 4/0xBEEF then 0/0x1234, and rr_ptr wraps from 4 to 0.
REQ-037 SHALL verify backpressure hold: up_ready low for 10 cycles -> up_data and up_id are unchanged every cycle.
